// File: rtl/jenc_mcu_scheduler.sv
// MCU scheduler between quantiser and entropy coder: tags coefficient pairs with
// pair index, component and last-MCU flag, then waits for end-of-stream or times out.
module jenc_mcu_scheduler #(
   parameter int unsigned MCU_BITS  = 10,
   parameter int unsigned FLUSH_TMO = 4096
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                abort,
   input  logic [MCU_BITS-1:0] cfg_mcu_x,
   input  logic [MCU_BITS-1:0] cfg_mcu_y,
   input  logic                cfg_420,
   input  logic                in_valid,
   output logic                in_hold,
   output logic                q_valid,
   input  logic                q_hold,
   output logic [4:0]          q_cnt,
   output logic [1:0]          q_chroma,
   output logic                q_last_mcu,
   input  logic                eos,
   output logic                busy,
   output logic                frame_done,
   output logic                err_cfg,
   output logic                err_timeout
);

   localparam int unsigned TMO_W = (FLUSH_TMO > 2) ? $clog2(FLUSH_TMO) : 1;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;

   logic [1:0]          state, state_nxt;
   logic [MCU_BITS-1:0] mcu_x, mcu_x_nxt, mcu_y, mcu_y_nxt;
   logic                mode_420, mode_420_nxt;
   logic [4:0]          pair_nxt;
   logic [2:0]          blk, blk_nxt;
   logic [MCU_BITS-1:0] col, col_nxt, row, row_nxt;
   logic [TMO_W-1:0]    tmo_cnt, tmo_nxt;
   logic [1:0]          chroma_nxt;
   logic                last_nxt, done_nxt, ecfg_nxt, etmo_nxt;
   logic                run, beat, final_beat;
   logic [2:0]          blk_last;
   logic [MCU_BITS-1:0] x_m1, y_m1;

   // component of a block within the MCU
   function automatic logic [1:0] chroma_of(input logic [2:0] b, input logic m420);
      logic [1:0] c;
      c = 2'd0;
      if (!m420)            c = b[1:0];
      else if (b == 3'd4)   c = 2'd1;
      else if (b == 3'd5)   c = 2'd2;
      return c;
   endfunction

   assign run        = (state == ST_RUN);
   // abort also holds the quantiser so no beat is lost in the abort cycle
   assign q_valid    = in_valid & run & ~abort;
   assign in_hold    = q_hold | ~run | abort;
   assign beat       = q_valid & ~q_hold;
   assign blk_last   = mode_420 ? 3'd5 : 3'd2;
   assign x_m1       = mcu_x - MCU_BITS'(1);
   assign y_m1       = mcu_y - MCU_BITS'(1);
   assign final_beat = (q_cnt == 5'd31) && (blk == blk_last) && q_last_mcu;

   always_comb begin
      state_nxt    = state;
      mcu_x_nxt    = mcu_x;
      mcu_y_nxt    = mcu_y;
      mode_420_nxt = mode_420;
      pair_nxt     = q_cnt;
      blk_nxt      = blk;
      col_nxt      = col;
      row_nxt      = row;
      tmo_nxt      = tmo_cnt;
      chroma_nxt   = q_chroma;
      last_nxt     = q_last_mcu;
      done_nxt     = 1'b0;
      ecfg_nxt     = 1'b0;
      etmo_nxt     = 1'b0;

      if (abort) begin
         state_nxt  = ST_IDLE;
         pair_nxt   = 5'd0;
         blk_nxt    = 3'd0;
         col_nxt    = '0;
         row_nxt    = '0;
         tmo_nxt    = '0;
         chroma_nxt = 2'd0;
         last_nxt   = 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               tmo_nxt = '0;
               if (start) begin
                  if ((cfg_mcu_x == '0) || (cfg_mcu_y == '0)) begin
                     ecfg_nxt = 1'b1;
                  end else begin
                     state_nxt    = ST_RUN;
                     mcu_x_nxt    = cfg_mcu_x;
                     mcu_y_nxt    = cfg_mcu_y;
                     mode_420_nxt = cfg_420;
                     last_nxt     = (cfg_mcu_x == MCU_BITS'(1)) && (cfg_mcu_y == MCU_BITS'(1));
                  end
               end
            end
            ST_RUN: begin
               tmo_nxt = '0;
               if (beat) begin
                  // pair -> block -> column -> row carry chain
                  if (q_cnt != 5'd31) begin
                     pair_nxt = q_cnt + 5'd1;
                  end else begin
                     pair_nxt = 5'd0;
                     if (blk != blk_last) begin
                        blk_nxt = blk + 3'd1;
                     end else begin
                        blk_nxt = 3'd0;
                        if (col != x_m1) begin
                           col_nxt = col + MCU_BITS'(1);
                        end else begin
                           col_nxt = '0;
                           row_nxt = (row != y_m1) ? row + MCU_BITS'(1) : '0;
                        end
                     end
                  end
                  chroma_nxt = chroma_of(blk_nxt, mode_420);
                  last_nxt   = (col_nxt == x_m1) && (row_nxt == y_m1);
                  if (final_beat) begin
                     state_nxt = ST_FLUSH;
                     last_nxt  = 1'b0;
                  end
               end
            end
            ST_FLUSH: begin
               if (eos) begin
                  state_nxt = ST_IDLE;
                  done_nxt  = 1'b1;
                  tmo_nxt   = '0;
               end else if (tmo_cnt == TMO_W'(FLUSH_TMO - 1)) begin
                  state_nxt = ST_IDLE;
                  etmo_nxt  = 1'b1;
                  tmo_nxt   = '0;
               end else begin
                  tmo_nxt = tmo_cnt + TMO_W'(1);
               end
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_IDLE;
         mcu_x       <= '0;
         mcu_y       <= '0;
         mode_420    <= 1'b0;
         q_cnt       <= 5'd0;
         blk         <= 3'd0;
         col         <= '0;
         row         <= '0;
         tmo_cnt     <= '0;
         q_chroma    <= 2'd0;
         q_last_mcu  <= 1'b0;
         busy        <= 1'b0;
         frame_done  <= 1'b0;
         err_cfg     <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         state       <= state_nxt;
         mcu_x       <= mcu_x_nxt;
         mcu_y       <= mcu_y_nxt;
         mode_420    <= mode_420_nxt;
         q_cnt       <= pair_nxt;
         blk         <= blk_nxt;
         col         <= col_nxt;
         row         <= row_nxt;
         tmo_cnt     <= tmo_nxt;
         q_chroma    <= chroma_nxt;
         q_last_mcu  <= last_nxt;
         busy        <= (state_nxt != ST_IDLE);
         frame_done  <= done_nxt;
         err_cfg     <= ecfg_nxt;
         err_timeout <= etmo_nxt;
      end
   end

endmodule

// File: tb/tb_jenc_mcu_scheduler.sv
// Scoreboard bench for jenc_mcu_scheduler: expected beat tags are queued by the
// stimulus and checked by an independent monitor on every accepted beat.
module tb_jenc_mcu_scheduler;

   localparam int unsigned MB  = 10;
   localparam int unsigned TMO = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          start, abort, cfg_420, in_valid, q_hold, eos;
   logic [MB-1:0] cfg_mcu_x, cfg_mcu_y;
   logic          in_hold, q_valid, q_last_mcu, busy, frame_done, err_cfg, err_timeout;
   logic [4:0]    q_cnt;
   logic [1:0]    q_chroma;

   jenc_mcu_scheduler #(.MCU_BITS(MB), .FLUSH_TMO(TMO)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .cfg_mcu_x(cfg_mcu_x), .cfg_mcu_y(cfg_mcu_y), .cfg_420(cfg_420),
      .in_valid(in_valid), .in_hold(in_hold), .q_valid(q_valid), .q_hold(q_hold),
      .q_cnt(q_cnt), .q_chroma(q_chroma), .q_last_mcu(q_last_mcu), .eos(eos),
      .busy(busy), .frame_done(frame_done), .err_cfg(err_cfg), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   logic [7:0] exp_q[$];
   logic [7:0] mon_e;
   int n_vec = 0;
   int n_err = 0;
   int got;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s actual=%0h required=%0h @%0t", name, act, req, $time);
      end
   endtask

   // monitor: every accepted beat must match the head of the expected queue
   always @(negedge clk) begin
      if (!reset && q_valid && !q_hold) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL beat_extra actual cnt=%0d chroma=%0d last=%0d required no beat",
                     q_cnt, q_chroma, q_last_mcu);
         end else begin
            mon_e = exp_q.pop_front();
            chk("beat_tag{cnt,chroma,last}", 32'({q_cnt, q_chroma, q_last_mcu}), 32'(mon_e));
         end
      end
   end

   task automatic push_frame(input int x, input int y, input bit m420, input int limit);
      int k = 0;
      int nb = m420 ? 6 : 3;
      int ch;
      bit last;
      for (int r = 0; r < y; r++)
         for (int c = 0; c < x; c++)
            for (int b = 0; b < nb; b++)
               for (int p = 0; p < 32; p++) begin
                  if (m420) ch = (b < 4) ? 0 : b - 3;
                  else      ch = b;
                  last = (c == x - 1) && (r == y - 1);
                  if (k < limit) exp_q.push_back({5'(p), 2'(ch), last});
                  k++;
               end
   endtask

   // called at posedge+1; DUT is in RUN after return
   task automatic start_frame(input int x, input int y, input bit m420);
      cfg_mcu_x = MB'(x);
      cfg_mcu_y = MB'(y);
      cfg_420   = m420;
      start     = 1'b1;
      @(posedge clk); #1;
      start     = 1'b0;
      cfg_mcu_x = MB'(7);
      cfg_mcu_y = MB'(7);
      cfg_420   = ~m420;
   endtask

   // drives in_valid until nbeats accepted; start and (optionally) eos held to show they are ignored
   task automatic stream(input int nbeats, input bit toggle, output int acc);
      int cyc = 0;
      acc = 0;
      while (acc < nbeats && cyc < 2000) begin
         in_valid = 1'b1;
         start    = 1'b1;
         q_hold   = toggle && ((cyc % 2) == 1);
         eos      = toggle;
         @(negedge clk);
         if (q_valid && !q_hold) acc++;
         @(posedge clk); #1;
         cyc++;
      end
      in_valid = 1'b0;
      start    = 1'b0;
      q_hold   = 1'b0;
      eos      = 1'b0;
   endtask

   initial begin
      reset = 1'b1; start = 0; abort = 0; cfg_420 = 0; in_valid = 0; q_hold = 0; eos = 0;
      cfg_mcu_x = '0; cfg_mcu_y = '0;
      #12 reset = 1'b0;
      @(negedge clk);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(frame_done), 0);
      chk("rst_err_cfg", 32'(err_cfg), 0);
      chk("rst_err_tmo", 32'(err_timeout), 0);
      chk("rst_q_cnt", 32'(q_cnt), 0);
      chk("rst_q_chroma", 32'(q_chroma), 0);
      chk("rst_q_last", 32'(q_last_mcu), 0);
      chk("rst_in_hold", 32'(in_hold), 1);
      @(posedge clk); #1;

      // 2x1 4:2:0 frame, continuous valid, eos 10 cycles after flush entry
      push_frame(2, 1, 1, 384);
      start_frame(2, 1, 1);
      chk("t1_busy_run", 32'(busy), 1);
      stream(384, 0, got);
      chk("t1_beats", 32'(got), 384);
      in_valid = 1'b1;
      @(negedge clk);
      chk("t1_flush_q_valid", 32'(q_valid), 0);
      chk("t1_flush_in_hold", 32'(in_hold), 1);
      chk("t1_flush_busy", 32'(busy), 1);
      chk("t1_flush_q_cnt", 32'(q_cnt), 0);
      in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1 eos = 1'b1;
      @(posedge clk); #1 eos = 1'b0;
      @(negedge clk);
      chk("t1_frame_done", 32'(frame_done), 1);
      chk("t1_busy_idle", 32'(busy), 0);
      chk("t1_no_timeout", 32'(err_timeout), 0);
      @(negedge clk);
      chk("t1_done_pulse", 32'(frame_done), 0);
      @(posedge clk); #1;

      // 1x2 4:4:4 with toggling q_hold and eos noise during RUN, then timeout
      push_frame(1, 2, 0, 192);
      start_frame(1, 2, 0);
      stream(192, 1, got);
      chk("t2_beats", 32'(got), 192);
      for (int k = 0; k <= 16; k++) begin
         @(negedge clk);
         chk("t2_err_timeout", 32'(err_timeout), (k == 16) ? 1 : 0);
         chk("t2_busy", 32'(busy), (k == 16) ? 0 : 1);
         chk("t2_no_done", 32'(frame_done), 0);
      end
      @(negedge clk);
      chk("t2_tmo_pulse", 32'(err_timeout), 0);
      @(posedge clk); #1;

      // zero dimension rejected
      for (int t = 0; t < 2; t++) begin
         cfg_mcu_x = (t == 0) ? MB'(0) : MB'(3);
         cfg_mcu_y = (t == 0) ? MB'(3) : MB'(0);
         start = 1'b1;
         @(posedge clk); #1 start = 1'b0;
         @(negedge clk);
         chk("t3_err_cfg", 32'(err_cfg), 1);
         chk("t3_busy", 32'(busy), 0);
         chk("t3_in_hold", 32'(in_hold), 1);
         @(negedge clk);
         chk("t3_err_cfg_pulse", 32'(err_cfg), 0);
         @(posedge clk); #1;
      end

      // abort at beat 100, then a full clean frame
      push_frame(2, 1, 1, 100);
      start_frame(2, 1, 1);
      stream(100, 0, got);
      chk("t4_beats", 32'(got), 100);
      abort = 1'b1;
      in_valid = 1'b1;
      @(negedge clk);
      chk("t4_abort_q_valid", 32'(q_valid), 0);
      chk("t4_abort_in_hold", 32'(in_hold), 1);
      @(posedge clk); #1 abort = 1'b0;
      @(negedge clk);
      chk("t4_busy", 32'(busy), 0);
      chk("t4_q_cnt", 32'(q_cnt), 0);
      chk("t4_q_chroma", 32'(q_chroma), 0);
      chk("t4_done", 32'(frame_done), 0);
      chk("t4_q_valid_idle", 32'(q_valid), 0);
      in_valid = 1'b0;
      @(posedge clk); #1;
      push_frame(2, 1, 1, 384);
      start_frame(2, 1, 1);
      stream(384, 0, got);
      chk("t4_restart_beats", 32'(got), 384);
      eos = 1'b1;
      @(posedge clk); #1 eos = 1'b0;
      @(negedge clk);
      chk("t4_restart_done", 32'(frame_done), 1);
      @(posedge clk); #1;

      // asynchronous reset mid-RUN, then a 1x1 frame finishing with eos on the timeout cycle
      push_frame(1, 1, 1, 50);
      start_frame(1, 1, 1);
      stream(50, 0, got);
      chk("t5_beats", 32'(got), 50);
      in_valid = 1'b1;
      #2 reset = 1'b1;
      #1;
      chk("t5_rst_busy", 32'(busy), 0);
      chk("t5_rst_q_cnt", 32'(q_cnt), 0);
      chk("t5_rst_q_last", 32'(q_last_mcu), 0);
      chk("t5_rst_q_valid", 32'(q_valid), 0);
      chk("t5_rst_in_hold", 32'(in_hold), 1);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      push_frame(1, 1, 0, 96);
      start_frame(1, 1, 0);
      @(negedge clk);
      chk("t5_last_first", 32'(q_last_mcu), 1);
      @(posedge clk); #1;
      stream(96, 0, got);
      chk("t5_clean_beats", 32'(got), 96);
      repeat (15) @(posedge clk);
      #1 eos = 1'b1;
      @(posedge clk); #1 eos = 1'b0;
      @(negedge clk);
      chk("t5_eos_on_tmo_done", 32'(frame_done), 1);
      chk("t5_eos_on_tmo_no_err", 32'(err_timeout), 0);
      chk("t5_busy", 32'(busy), 0);

      chk("queue_empty", 32'(exp_q.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
